fre_sweep_pwm: RTL and testbench
================================

Name: fre_sweep_pwm

Overview:
- Consumes the 24-bit sweep settings fre_max, fre_min and fre_step produced by the UART command parser.
- Sweeps an NCO tuning word from fre_min to fre_max in fre_step increments, holding each value for a fixed dwell time.
- Drives a PWM output whose duty is set by an 8-bit compare value.
- Sits between the UART configuration stage and the board PWM pin.

Parameters:
- FRE_W, 24: width of the frequency / tuning-word fields.
- ACC_W, 32: phase accumulator width.
- DWELL_CYC, 50000: clk cycles spent at each frequency step (≥1).

Ports:
- clk  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- sweep_en  in  1  level; 1 = run the sweep, 0 = idle.
- one_shot  in  1  1 = stop at the top of the sweep; 0 = repeat the sweep.
- fre_max  in  FRE_W  upper tuning word.
- fre_min  in  FRE_W  lower tuning word.
- fre_step  in  FRE_W  increment per dwell period.
- duty  in  8  PWM compare value.
- pwm_out  out  1  PWM output.
- cur_fre  out  FRE_W  tuning word currently applied.
- busy  out  1  high in CHECK or RUN.
- sweep_done  out  1  high in HOLD (one-shot sweep finished).
- cfg_err  out  1  high in ERR (fre_min > fre_max).

Behaviour:
- Reset (async, RSTn=0): state=IDLE, phase=0, cur_fre=0, dwell_cnt=0, shadow registers=0, all outputs 0.
- Shadow registers sample fre_max/fre_min/fre_step every cycle. Any mismatch with the live inputs while not in IDLE forces state CHECK on the next edge, which restarts the sweep.
- sweep_en=0 in any state: next edge goes to IDLE, clears phase and dwell_cnt, forces pwm_out=0. cur_fre holds its last value.
- IDLE: when sweep_en=1, go to CHECK on the next edge.
- CHECK (1 cycle):
  - fre_min > fre_max → ERR.
  - Otherwise → RUN with cur_fre=fre_min, dwell_cnt=0, phase=0.
- RUN:
  - Every cycle: phase <= phase + zero-extended cur_fre, modulo 2^ACC_W.
  - dwell_cnt counts 0..DWELL_CYC-1.
  - At the terminal count, compute nxt = cur_fre + fre_step in FRE_W+1 bits:
    - nxt ≤ fre_max → cur_fre <= nxt.
    - nxt > fre_max and one_shot=0 → cur_fre <= fre_min (wrap).
    - nxt > fre_max and one_shot=1 → HOLD; cur_fre keeps the last valid value.
  - fre_step=0: cur_fre stays at fre_min indefinitely; never enters HOLD.
  - fre_min==fre_max: single frequency. The wrap reloads the same value; one-shot enters HOLD after the first dwell.
- HOLD: phase keeps accumulating at cur_fre and pwm_out stays active. Leaves only on config change (→ CHECK) or sweep_en=0 (→ IDLE).
- ERR: pwm_out=0, phase frozen. Leaves on config change (→ CHECK) or sweep_en=0 (→ IDLE).
- PWM: pwm_out is registered, = (phase[ACC_W-1:ACC_W-8] < duty) in RUN/HOLD, 0 otherwise.
  - duty=0 → constantly 0.
  - duty=255 → low 1/256 of each period.
- Latency: sweep_en rising at edge N → CHECK at N+1 → RUN with cur_fre=fre_min at N+2 → first phase increment at N+3.
- Simultaneous config change and dwell terminal count: config change wins (→ CHECK).
- Output frequency = cur_fre × f_clk / 2^ACC_W.

Optional Feature:
- Macro SWEEP_TRIANGLE_EN.
- Defined: a direction flag is added. On nxt > fre_max the sweep reverses and counts down by fre_step. When the next value would fall below fre_min, it reverses back up, computed with a borrow check.
  - one_shot=1: enters HOLD only after returning to the bottom.
  - CHECK resets direction to up.
- Undefined: sawtooth wrap as above; no direction flag is synthesised.

Decomposition:
- Package fre_sweep_pkg: FRE_W, ACC_W, state enum {IDLE, CHECK, RUN, HOLD, ERR}.
- Sub-module nco_pwm:
  - Function: phase accumulator plus 8-bit compare.
  - Inputs: clk, RSTn, run, tuning word, duty.
  - Output: pwm_out.
- Top level holds the FSM, dwell counter, shadow registers and step arithmetic.

Test Plan (DWELL_CYC=4):
- Sawtooth: min=10, max=30, step=10, one_shot=0, sweep_en=1 → cur_fre sequence 10,20,30,10,… with each value held 4 cycles; busy=1.
- One-shot: same settings, one_shot=1 → after the 30 dwell, sweep_done=1 and cur_fre=30 held; pwm_out keeps toggling.
- Error and recovery: min=40, max=30 → cfg_err=1 two cycles after sweep_en, pwm_out=0; then change min to 5 → CHECK, RUN with cur_fre=5.
- Mid-sweep change: change fre_step while cur_fre=20 → next cycle CHECK, then cur_fre=fre_min; dwell restarts.
- PWM duty: cur_fre=2^24-1, duty=0 → pwm_out never 1; duty=128 → high ≈50% of each phase period (±1 cycle).
- Resets: assert RSTn=0 mid-RUN → all outputs 0 immediately; sweep_en=0 mid-RUN → IDLE next edge, pwm_out=0, cur_fre held.
- SWEEP_TRIANGLE_EN build: min=10, max=30, step=10 → cur_fre 10,20,30,20,10,20,…

Source files
------------

// File: rtl/fre_sweep_pkg.sv
// Shared widths, sweep FSM states and the configuration payload for fre_sweep_pwm.
package fre_sweep_pkg;

    localparam int unsigned FRE_W = 24;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned PWM_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        HOLD  = 3'd3,
        ERR   = 3'd4
    } state_e;

    typedef struct packed {
        logic [FRE_W-1:0] fmax;
        logic [FRE_W-1:0] fmin;
        logic [FRE_W-1:0] fstep;
    } sweep_cfg_t;

endpackage

// File: rtl/fre_sweep_pwm_nco.sv
// NCO phase accumulator with an 8-bit compare driving a registered PWM output.
module nco_pwm
    import fre_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             RSTn,
    input  logic             run_i,
    input  logic [FRE_W-1:0] tw_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             pwm_o
);

    logic [ACC_W-1:0] phase_q, phase_d;
    logic             pwm_q, pwm_d;

    // Phase restarts from zero whenever the oscillator is not running.
    always_comb begin
        phase_d = '0;
        pwm_d   = 1'b0;
        if (run_i) begin
            phase_d = phase_q + ACC_W'(tw_i);
            pwm_d   = (phase_q[ACC_W-1 -: PWM_W] < duty_i);
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            phase_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/fre_sweep_pwm.sv
// Frequency-sweep controller: steps an NCO tuning word between fre_min and fre_max.
// Optional macro SWEEP_TRIANGLE_EN selects an up/down (triangle) sweep instead of sawtooth.
module fre_sweep_pwm
    import fre_sweep_pkg::*;
#(
    parameter int unsigned DWELL_CYC = 50000
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             sweep_en,
    input  logic             one_shot,
    input  logic [FRE_W-1:0] fre_max,
    input  logic [FRE_W-1:0] fre_min,
    input  logic [FRE_W-1:0] fre_step,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_out,
    output logic [FRE_W-1:0] cur_fre,
    output logic             busy,
    output logic             sweep_done,
    output logic             cfg_err
);

    localparam int unsigned DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYC - 1);

    state_e           state_q, state_d;
    sweep_cfg_t       shadow_q, live_c;
    logic [FRE_W-1:0] cur_q, cur_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             busy_q, done_q, err_q;
    logic [FRE_W:0]   up_c;
    logic             up_ok_c, cfg_chg_c, run_c;
`ifdef SWEEP_TRIANGLE_EN
    logic             dir_dn_q, dir_dn_d;
    logic [FRE_W:0]   dn_c;
    logic             dn_ok_c;
`endif

    assign live_c    = '{fmax: fre_max, fmin: fre_min, fstep: fre_step};
    assign cfg_chg_c = (shadow_q != live_c) && (state_q != IDLE);
    // Extra carry bit keeps the upper-bound test exact near 2^FRE_W.
    assign up_c      = {1'b0, cur_q} + {1'b0, fre_step};
    assign up_ok_c   = (up_c <= {1'b0, fre_max});
`ifdef SWEEP_TRIANGLE_EN
    assign dn_c      = {1'b0, cur_q} - {1'b0, fre_step};
    assign dn_ok_c   = !dn_c[FRE_W] && (dn_c[FRE_W-1:0] >= fre_min);
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;
`ifdef SWEEP_TRIANGLE_EN
        dir_dn_d = dir_dn_q;
`endif
        if (!sweep_en) begin
            state_d = IDLE;
            dwell_d = '0;
        end else if (cfg_chg_c) begin
            state_d = CHECK;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                IDLE:  state_d = CHECK;
                CHECK: begin
`ifdef SWEEP_TRIANGLE_EN
                    dir_dn_d = 1'b0;
`endif
                    if (fre_min > fre_max) begin
                        state_d = ERR;
                    end else begin
                        state_d = RUN;
                        cur_d   = fre_min;
                        dwell_d = '0;
                    end
                end
                RUN: begin
                    dwell_d = dwell_q + DW_W'(1);
                    if (dwell_q == DW_LAST) begin
                        dwell_d = '0;
`ifdef SWEEP_TRIANGLE_EN
                        if (!dir_dn_q) begin
                            if (up_ok_c) begin
                                cur_d = up_c[FRE_W-1:0];
                            end else begin
                                dir_dn_d = 1'b1;
                                if (dn_ok_c) cur_d = dn_c[FRE_W-1:0];
                            end
                        end else if (dn_ok_c) begin
                            cur_d = dn_c[FRE_W-1:0];
                        end else if (one_shot) begin
                            state_d = HOLD;
                        end else begin
                            dir_dn_d = 1'b0;
                            if (up_ok_c) cur_d = up_c[FRE_W-1:0];
                        end
`else
                        if (up_ok_c) begin
                            cur_d = up_c[FRE_W-1:0];
                        end else if (!one_shot) begin
                            cur_d = fre_min;
                        end else begin
                            state_d = HOLD;
                        end
`endif
                    end
                end
                HOLD:    dwell_d = '0;
                ERR:     dwell_d = '0;
                default: state_d = IDLE;
            endcase
        end
    end

    // Accumulate only while staying in an active state; any exit clears phase and PWM.
    assign run_c = (state_q inside {RUN, HOLD}) && (state_d inside {RUN, HOLD});

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cur_q    <= '0;
            dwell_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= live_c;
            cur_q    <= cur_d;
            dwell_q  <= dwell_d;
            busy_q   <= (state_d == CHECK) || (state_d == RUN);
            done_q   <= (state_d == HOLD);
            err_q    <= (state_d == ERR);
        end
    end

`ifdef SWEEP_TRIANGLE_EN
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) dir_dn_q <= 1'b0;
        else       dir_dn_q <= dir_dn_d;
    end
`endif

    nco_pwm u_nco (
        .clk    (clk),
        .RSTn   (RSTn),
        .run_i  (run_c),
        .tw_i   (cur_q),
        .duty_i (duty),
        .pwm_o  (pwm_out)
    );

    assign cur_fre    = cur_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_fre_sweep_pwm.sv
// Bench for fre_sweep_pwm with DWELL_CYC=4: cycle model compare plus directed literal checks.
module tb_fre_sweep_pwm;

    localparam int DWELL = 4;
    localparam int M_IDLE = 0, M_CHECK = 1, M_RUN = 2, M_HOLD = 3, M_ERR = 4;

    logic        clk = 1'b0;
    logic        RSTn;
    logic        sweep_en, one_shot;
    logic [23:0] fre_max, fre_min, fre_step;
    logic [7:0]  duty;
    logic        pwm_out, busy, sweep_done, cfg_err;
    logic [23:0] cur_fre;

    int checks = 0;
    int errors = 0;

    fre_sweep_pwm #(.DWELL_CYC(DWELL)) dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .sweep_en   (sweep_en),
        .one_shot   (one_shot),
        .fre_max    (fre_max),
        .fre_min    (fre_min),
        .fre_step   (fre_step),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .cur_fre    (cur_fre),
        .busy       (busy),
        .sweep_done (sweep_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: state name, applied word, cycles spent at it, phase as plain integer.
    int      m_st, m_cur, m_age, m_dn, m_smax, m_smin, m_sstep;
    longint  m_ph;
    bit      m_pwm;
    int      n_st, n_cur, n_age, n_dn, up, dn, mx, mn;
    longint  n_ph;
    bit      n_pwm, chg;

    always @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            m_st = M_IDLE; m_cur = 0; m_age = 0; m_dn = 0; m_ph = 0; m_pwm = 0;
            m_smax = 0; m_smin = 0; m_sstep = 0;
        end else begin
            mx = int'(fre_max); mn = int'(fre_min);
            up = m_cur + int'(fre_step);
            dn = m_cur - int'(fre_step);
            chg = (m_st != M_IDLE) &&
                  (m_smax != mx || m_smin != mn || m_sstep != int'(fre_step));
            n_st = m_st; n_cur = m_cur; n_age = m_age; n_dn = m_dn;
            if (!sweep_en) begin
                n_st = M_IDLE; n_age = 0;
            end else if (chg) begin
                n_st = M_CHECK; n_age = 0;
            end else if (m_st == M_IDLE) begin
                n_st = M_CHECK;
            end else if (m_st == M_CHECK) begin
                n_dn = 0;
                if (mn > mx) n_st = M_ERR;
                else begin n_st = M_RUN; n_cur = mn; n_age = 0; end
            end else if (m_st == M_RUN) begin
                if (m_age < DWELL - 1) n_age = m_age + 1;
                else begin
                    n_age = 0;
`ifdef SWEEP_TRIANGLE_EN
                    if (m_dn == 0) begin
                        if (up <= mx) n_cur = up;
                        else begin n_dn = 1; if (dn >= mn) n_cur = dn; end
                    end else if (dn >= mn) n_cur = dn;
                    else if (one_shot) n_st = M_HOLD;
                    else begin n_dn = 0; if (up <= mx) n_cur = up; end
`else
                    if (up <= mx) n_cur = up;
                    else if (!one_shot) n_cur = mn;
                    else n_st = M_HOLD;
`endif
                end
            end else if (m_st == M_HOLD) begin
                n_age = 0;
            end
            if ((m_st == M_RUN || m_st == M_HOLD) && (n_st == M_RUN || n_st == M_HOLD)) begin
                n_pwm = ((m_ph >> 24) < longint'(duty));
                n_ph  = (m_ph + longint'(m_cur)) % 64'h1_0000_0000;
            end else begin
                n_pwm = 1'b0;
                n_ph  = (n_st == M_ERR) ? m_ph : 0;
            end
            m_st = n_st; m_cur = n_cur; m_age = n_age; m_dn = n_dn; m_ph = n_ph; m_pwm = n_pwm;
            m_smax = mx; m_smin = mn; m_sstep = int'(fre_step);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (RSTn === 1'b1) begin
            checks++;
            if (pwm_out !== m_pwm || cur_fre !== 24'(m_cur) ||
                busy !== (m_st == M_CHECK || m_st == M_RUN) ||
                sweep_done !== (m_st == M_HOLD) || cfg_err !== (m_st == M_ERR)) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got pwm=%0b cur=%0d busy=%0b done=%0b err=%0b, expected pwm=%0b cur=%0d state=%0d",
                         $time, pwm_out, cur_fre, busy, sweep_done, cfg_err, m_pwm, m_cur, m_st);
            end
        end
    end

    task automatic lit(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_sweep(input int mn, input int mx, input int st, input bit os);
        sweep_en = 1'b0;
        fre_min = 24'(mn); fre_max = 24'(mx); fre_step = 24'(st); one_shot = os;
        cyc(2);
        sweep_en = 1'b1;
    endtask

    int hi;

    initial begin
        RSTn = 1'b0; sweep_en = 1'b0; one_shot = 1'b0;
        fre_max = '0; fre_min = '0; fre_step = '0; duty = 8'd128;
        cyc(2);
        lit("reset_cur_fre", longint'(cur_fre), 0);
        lit("reset_flags", longint'({pwm_out, busy, sweep_done, cfg_err}), 0);
        RSTn = 1'b1;
        cyc(2);

        // Sawtooth 10,20,30,10 with 4-cycle dwell.
        start_sweep(10, 30, 10, 1'b0);
        cyc(1); lit("saw_check_busy", longint'(busy), 1);
        lit("saw_check_cur", longint'(cur_fre), 0);
        cyc(1); lit("saw_first", longint'(cur_fre), 10);
        cyc(4); lit("saw_second", longint'(cur_fre), 20);
        cyc(4); lit("saw_top", longint'(cur_fre), 30);
        cyc(4); lit("saw_wrap", longint'(cur_fre), 10);
        lit("saw_busy", longint'(busy), 1);
        cyc(4); lit("saw_again20", longint'(cur_fre), 20);

        // Step change while at 20 restarts from fre_min.
        fre_step = 24'd5;
        cyc(1); lit("chg_check_busy", longint'(busy), 1);
        lit("chg_check_cur", longint'(cur_fre), 20);
        cyc(1); lit("chg_restart", longint'(cur_fre), 10);
        cyc(4); lit("chg_step5", longint'(cur_fre), 15);

        // sweep_en low mid-RUN.
        sweep_en = 1'b0;
        cyc(1);
        lit("dis_busy", longint'(busy), 0);
        lit("dis_pwm", longint'(pwm_out), 0);
        lit("dis_cur_held", longint'(cur_fre), 15);

        // One-shot stops on the top value.
        start_sweep(10, 30, 10, 1'b1);
        cyc(2); lit("os_first", longint'(cur_fre), 10);
        cyc(8); lit("os_top", longint'(cur_fre), 30);
        lit("os_not_done", longint'(sweep_done), 0);
        cyc(4); lit("os_done", longint'(sweep_done), 1);
        lit("os_hold_cur", longint'(cur_fre), 30);
        lit("os_hold_pwm", longint'(pwm_out), 1);
        lit("os_hold_busy", longint'(busy), 0);
        cyc(10); lit("os_still_done", longint'(sweep_done), 1);

        // Bad range, then recovery by lowering fre_min.
        start_sweep(40, 30, 10, 1'b0);
        cyc(1); lit("err_not_yet", longint'(cfg_err), 0);
        cyc(1); lit("err_set", longint'(cfg_err), 1);
        lit("err_pwm", longint'(pwm_out), 0);
        cyc(3); lit("err_stays", longint'(cfg_err), 1);
        fre_min = 24'd5;
        cyc(1); lit("rec_check", longint'({busy, cfg_err}), 2);
        cyc(1); lit("rec_cur", longint'(cur_fre), 5);

        // Duty 0 never drives high at the largest tuning word.
        duty = 8'd0;
        start_sweep(24'hFF_FFFF, 24'hFF_FFFF, 0, 1'b0);
        cyc(3);
        hi = 0;
        for (int i = 0; i < 300; i++) begin cyc(1); hi += int'(pwm_out); end
        lit("duty0_high_cycles", longint'(hi), 0);
        lit("duty0_cur", longint'(cur_fre), 24'hFF_FFFF);

        // Duty 128: about half of a 256-cycle phase period.
        duty = 8'd128;
        cyc(2);
        hi = 0;
        for (int i = 0; i < 256; i++) begin cyc(1); hi += int'(pwm_out); end
        lit("duty128_near_half", longint'(hi >= 127 && hi <= 129), 1);

        // Asynchronous reset between edges clears everything at once.
        start_sweep(10, 30, 10, 1'b0);
        cyc(7);
        #2 RSTn = 1'b0;
        #1;
        lit("areset_cur", longint'(cur_fre), 0);
        lit("areset_flags", longint'({pwm_out, busy, sweep_done, cfg_err}), 0);
        @(negedge clk); RSTn = 1'b1;
        cyc(1); lit("post_reset_check", longint'(busy), 1);
        cyc(1); lit("post_reset_run", longint'(cur_fre), 10);

`ifdef SWEEP_TRIANGLE_EN
        start_sweep(10, 30, 10, 1'b0);
        cyc(2);  lit("tri_10", longint'(cur_fre), 10);
        cyc(4);  lit("tri_20", longint'(cur_fre), 20);
        cyc(4);  lit("tri_30", longint'(cur_fre), 30);
        cyc(4);  lit("tri_down20", longint'(cur_fre), 20);
        cyc(4);  lit("tri_down10", longint'(cur_fre), 10);
        cyc(4);  lit("tri_up20", longint'(cur_fre), 20);
`endif
        cyc(5);
        sweep_en = 1'b0;
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
